// File: rtl/mem_pkg.sv
// Shared definitions for the load/store path: RISC-V funct3 size codes,
// the access FSM state encoding and a size decode helper.
package mem_pkg;

    localparam logic [2:0] F3_B = 3'b000;
    localparam logic [2:0] F3_H = 3'b001;
    localparam logic [2:0] F3_W = 3'b010;
    localparam logic [2:0] F3_D = 3'b011;
    localparam int         F3_UNSIGNED_BIT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    // Access size in bytes from funct3[1:0]
    function automatic logic [3:0] f3_size(input logic [2:0] f3);
        return 4'd1 << f3[1:0];
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: builds lane enables and replicated store data, and
// extracts plus sign/zero-extends load data from a bus word.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int NB     = DATA_W / 8,
    localparam int OFF_W  = $clog2(NB)
) (
    input  logic [2:0]        funct3,
    input  logic [OFF_W-1:0]  off,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] rdata,
    output logic [NB-1:0]     byte_en,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data
);

    logic [3:0]        size;
    logic [DATA_W-1:0] shifted;
    logic              sign;

    always_comb begin
        size    = f3_size(funct3);
        shifted = rdata >> (8 * int'(off));
        sign    = 1'b0;
        case (funct3[1:0])
            F3_B[1:0]: sign = shifted[7];
            F3_H[1:0]: sign = shifted[15];
            F3_W[1:0]: sign = shifted[31];
            F3_D[1:0]: sign = shifted[DATA_W-1];
            default:   sign = 1'b0;
        endcase
        if (funct3[F3_UNSIGNED_BIT]) begin
            sign = 1'b0;
        end
        byte_en   = '0;
        wdata     = '0;
        load_data = '0;
        // size is a power of two, so masking the lane index replicates the low bytes
        for (int i = 0; i < NB; i++) begin
            byte_en[i]          = (i >= int'(off)) && (i < int'(off) + int'(size));
            wdata[8*i +: 8]     = store_data[8*(i & (int'(size) - 1)) +: 8];
            load_data[8*i +: 8] = (i < int'(size)) ? shifted[8*i +: 8] : {8{sign}};
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Pipelined load/store stage: legality/alignment check, byte-lane memory port
// with ce/we/ack wait states and timeout, and extended load return.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int ADDR_W  = 32,
    parameter  int TIMEOUT = 16,
    localparam int NB      = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read_mem,
    input  logic              write_mem,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] result,
    input  logic [DATA_W-1:0] store_data,
    output logic              ce,
    output logic              we,
    output logic [ADDR_W-1:0] data_addr,
    output logic [NB-1:0]     byte_en,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    input  logic              ack,
    output logic              stall,
    output logic [DATA_W-1:0] load_data,
    output logic              load_valid,
    output logic              addr_fault,
    output logic              bus_err,
    output mem_state_t        state
);

    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    mem_state_t        next_state;
    logic              req;
    logic              illegal;
    logic              misaligned;
    logic              accept;
    logic              fault;
    logic              finish_ok;
    logic              timeout;
    logic [3:0]        size;
    logic [OFF_W-1:0]  off;
    logic [OFF_W-1:0]  off_q;
    logic [OFF_W-1:0]  align_off;
    logic [2:0]        f3_q;
    logic [2:0]        align_f3;
    logic              is_load_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic [NB-1:0]     lane_be;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] lane_load;

    assign req        = read_mem | write_mem;
    assign off        = result[OFF_W-1:0];
    assign size       = f3_size(funct3);
    assign illegal    = (int'(size) > NB) || (funct3[F3_UNSIGNED_BIT] && (int'(size) == NB));
    assign misaligned = |(4'(off) & (size - 4'd1));

    // Store side uses the live request in IDLE; load side uses the captured access
    mem_lane_align #(.DATA_W(DATA_W)) u_align (
        .funct3     (align_f3),
        .off        (align_off),
        .store_data (store_data),
        .rdata      (rdata),
        .byte_en    (lane_be),
        .wdata      (lane_wdata),
        .load_data  (lane_load)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        stall      = 1'b0;
        accept     = 1'b0;
        fault      = 1'b0;
        finish_ok  = 1'b0;
        timeout    = 1'b0;
        align_f3   = f3_q;
        align_off  = off_q;
        unique case (state)
            IDLE: begin
                stall     = req;
                align_f3  = funct3;
                align_off = off;
                if (req) begin
                    if (illegal || misaligned) begin
                        fault      = 1'b1;
                        next_state = DONE;
                    end else begin
                        accept     = 1'b1;
                        next_state = BUSY;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (ack) begin
                    finish_ok  = 1'b1;
                    next_state = DONE;
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    timeout    = 1'b1;
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        // A held request must not stall the pipeline while reset is asserted
        if (!rst_n) begin
            stall = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce         <= 1'b0;
            we         <= 1'b0;
            data_addr  <= '0;
            byte_en    <= '0;
            wdata      <= '0;
            load_data  <= '0;
            load_valid <= 1'b0;
            addr_fault <= 1'b0;
            bus_err    <= 1'b0;
            f3_q       <= '0;
            off_q      <= '0;
            is_load_q  <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            load_valid <= 1'b0;
            addr_fault <= 1'b0;
            bus_err    <= 1'b0;
            if (fault) begin
                addr_fault <= 1'b1;
            end
            if (accept) begin
                ce        <= 1'b1;
                we        <= write_mem & ~read_mem;
                data_addr <= {result[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                byte_en   <= lane_be;
                wdata     <= lane_wdata;
                f3_q      <= funct3;
                off_q     <= off;
                is_load_q <= read_mem;
                wait_cnt  <= '0;
            end
            if ((state == BUSY) && !ack && !timeout) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (finish_ok || timeout) begin
                ce      <= 1'b0;
                we      <= 1'b0;
                byte_en <= '0;
            end
            if (finish_ok && is_load_q) begin
                load_data  <= lane_load;
                load_valid <= 1'b1;
            end
            if (timeout) begin
                bus_err   <= 1'b1;
                load_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 32-bit and a 64-bit instance (TIMEOUT=4),
// directed cases plus randomized accesses against a byte-level reference model.
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic rd, wr, sel, ack_r;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [63:0] sd, rdat;

    logic read_mem32, write_mem32, ack32, read_mem64, write_mem64, ack64;
    assign read_mem32  = rd & ~sel;
    assign write_mem32 = wr & ~sel;
    assign ack32       = ack_r & ~sel;
    assign read_mem64  = rd & sel;
    assign write_mem64 = wr & sel;
    assign ack64       = ack_r & sel;

    logic        ce32, we32, stall32, lv32, af32, be32;
    logic [31:0] data_addr32, wdata32, load_data32;
    logic [3:0]  byte_en32;
    mem_state_t  state32;
    logic        ce64, we64, stall64, lv64, af64, be64;
    logic [31:0] data_addr64;
    logic [63:0] wdata64, load_data64;
    logic [7:0]  byte_en64;
    mem_state_t  state64;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TMO)) dut32 (
        .clk(clk), .rst_n(rst_n), .read_mem(read_mem32), .write_mem(write_mem32),
        .funct3(f3), .result(addr), .store_data(sd[31:0]), .ce(ce32), .we(we32),
        .data_addr(data_addr32), .byte_en(byte_en32), .wdata(wdata32),
        .rdata(rdat[31:0]), .ack(ack32), .stall(stall32), .load_data(load_data32),
        .load_valid(lv32), .addr_fault(af32), .bus_err(be32), .state(state32)
    );

    mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(TMO)) dut64 (
        .clk(clk), .rst_n(rst_n), .read_mem(read_mem64), .write_mem(write_mem64),
        .funct3(f3), .result(addr), .store_data(sd), .ce(ce64), .we(we64),
        .data_addr(data_addr64), .byte_en(byte_en64), .wdata(wdata64),
        .rdata(rdat), .ack(ack64), .stall(stall64), .load_data(load_data64),
        .load_valid(lv64), .addr_fault(af64), .bus_err(be64), .state(state64)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic        cur_ce, cur_we, cur_stall, cur_lv, cur_af, cur_be;
    logic [31:0] cur_addr;
    logic [7:0]  cur_byte_en;
    logic [63:0] cur_wdata, cur_ld;

    int          obs_cycles, obs_stall_cycles, obs_ce_cycles, obs_pulses;
    logic        obs_lv, obs_af, obs_be, obs_we, obs_moved, obs_saw_ce;
    logic [31:0] obs_addr;
    logic [7:0]  obs_byte_en;
    logic [63:0] obs_wdata, obs_ld;

    // ---------------- reference model ----------------
    function automatic logic [63:0] m_mask(int size);
        return (size >= 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * size)) - 64'd1);
    endfunction

    function automatic bit m_fault(int nb, logic [2:0] mf3, logic [31:0] a);
        int size = 1 << mf3[1:0];
        if (size > nb) return 1'b1;
        if (mf3[2] && size == nb) return 1'b1;
        return (a % size) != 0;
    endfunction

    function automatic logic [7:0] m_be(int nb, logic [2:0] mf3, logic [31:0] a);
        int size = 1 << mf3[1:0];
        int off  = int'(a % nb);
        return 8'(((1 << size) - 1) << off);
    endfunction

    function automatic logic [63:0] m_wdata(int nb, logic [2:0] mf3, logic [63:0] v);
        int size = 1 << mf3[1:0];
        logic [63:0] piece = v & m_mask(size);
        logic [63:0] w = '0;
        for (int k = 0; k < nb / size; k++) w = w | (piece << (8 * size * k));
        return w;
    endfunction

    function automatic logic [63:0] m_load(int nb, logic [2:0] mf3, logic [31:0] a, logic [63:0] r);
        int size = 1 << mf3[1:0];
        int off  = int'(a % nb);
        logic [63:0] v = (r >> (8 * off)) & m_mask(size);
        if (!mf3[2] && v[8*size-1]) v = v | ~m_mask(size);
        if (nb == 4) v = v & 64'h0000_0000_FFFF_FFFF;
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic sample_outputs();
        if (sel) begin
            cur_ce = ce64; cur_we = we64; cur_stall = stall64; cur_addr = data_addr64;
            cur_byte_en = byte_en64; cur_wdata = wdata64; cur_ld = load_data64;
            cur_lv = lv64; cur_af = af64; cur_be = be64;
        end else begin
            cur_ce = ce32; cur_we = we32; cur_stall = stall32; cur_addr = data_addr32;
            cur_byte_en = {4'b0, byte_en32}; cur_wdata = {32'b0, wdata32};
            cur_ld = {32'b0, load_data32}; cur_lv = lv32; cur_af = af32; cur_be = be32;
        end
    endtask

    task automatic drive_access(input logic sel_i, input logic rd_i, input logic wr_i,
                                input logic [2:0] f3_i, input logic [31:0] addr_i,
                                input logic [63:0] sd_i, input logic [63:0] rdata_i,
                                input int wait_i);
        int cyc = 0;
        int busy_seen = 0;
        bit done = 1'b0;
        obs_cycles = 0; obs_stall_cycles = 0; obs_ce_cycles = 0; obs_pulses = 0;
        obs_lv = 0; obs_af = 0; obs_be = 0; obs_we = 0; obs_moved = 0; obs_saw_ce = 0;
        obs_addr = '0; obs_byte_en = '0; obs_wdata = '0; obs_ld = '0;
        @(posedge clk); #1;
        sel = sel_i; rd = rd_i; wr = wr_i; f3 = f3_i; addr = addr_i;
        sd = sd_i; rdat = rdata_i; ack_r = 1'b0;
        while (!done && cyc < 40) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
                sample_outputs();
                ack_r = cur_ce && (busy_seen == wait_i);
            end
            @(negedge clk);
            sample_outputs();
            cyc++;
            if (cur_stall) obs_stall_cycles++;
            obs_pulses += int'(cur_lv) + int'(cur_af) + int'(cur_be);
            if (cur_ce) begin
                if (!obs_saw_ce) begin
                    obs_saw_ce = 1'b1; obs_we = cur_we; obs_addr = cur_addr;
                    obs_byte_en = cur_byte_en; obs_wdata = cur_wdata;
                end else if (cur_we !== obs_we || cur_addr !== obs_addr ||
                             cur_byte_en !== obs_byte_en || cur_wdata !== obs_wdata) begin
                    obs_moved = 1'b1;
                end
                obs_ce_cycles++;
                busy_seen++;
            end
            if (cyc > 1 && !cur_stall) begin
                done = 1'b1; obs_cycles = cyc;
                obs_lv = cur_lv; obs_af = cur_af; obs_be = cur_be; obs_ld = cur_ld;
            end
        end
        rd = 1'b0; wr = 1'b0; ack_r = 1'b0;
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL completion: access never released stall after %0d cycles", cyc);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; sel = 1'b0; rd = 1'b1; wr = 1'b0; f3 = F3_W; addr = 32'h100;
        sd = '0; rdat = '0; ack_r = 1'b0;
        #23;
        n_checks++;
        if ({ce32, we32, stall32, lv32, af32, be32} !== 6'b0) begin
            n_errors++; $display("FAIL reset_ctrl32: got %b expected 000000", {ce32, we32, stall32, lv32, af32, be32});
        end
        n_checks++;
        if ({data_addr32, byte_en32, wdata32, load_data32} !== 100'b0) begin
            n_errors++; $display("FAIL reset_bus32: addr %h be %b wdata %h ld %h expected zeros", data_addr32, byte_en32, wdata32, load_data32);
        end
        n_checks++;
        if (state32 !== IDLE || state64 !== IDLE) begin
            n_errors++; $display("FAIL reset_state: got %0d/%0d expected IDLE", state32, state64);
        end
        n_checks++;
        if ({ce64, stall64, load_data64, wdata64, byte_en64} !== 138'b0) begin
            n_errors++; $display("FAIL reset64: ce %b stall %b ld %h expected zeros", ce64, stall64, load_data64);
        end
        rd = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_store_word();
        drive_access(1'b0, 1'b0, 1'b1, F3_W, 32'h104, 64'hDEADBEEF, 64'h0, 0);
        n_checks++;
        if (obs_addr !== 32'h104 || obs_byte_en !== 8'h0F || obs_we !== 1'b1) begin
            n_errors++; $display("FAIL sw_bus: addr %h be %h we %b expected 104 0f 1", obs_addr, obs_byte_en, obs_we);
        end
        n_checks++;
        if (obs_wdata !== 64'hDEADBEEF) begin
            n_errors++; $display("FAIL sw_wdata: got %h expected deadbeef", obs_wdata);
        end
        n_checks++;
        if (obs_stall_cycles !== 2 || obs_pulses !== 0 || obs_cycles !== 3) begin
            n_errors++; $display("FAIL sw_timing: stall %0d pulses %0d cycles %0d expected 2 0 3", obs_stall_cycles, obs_pulses, obs_cycles);
        end
    endtask

    task automatic test_load_byte();
        drive_access(1'b0, 1'b1, 1'b0, F3_B, 32'h203, 64'h80123456, 64'h80123456, 2);
        n_checks++;
        if (obs_byte_en !== 8'h08 || obs_ld !== 64'hFFFF_FF80) begin
            n_errors++; $display("FAIL lb: be %h ld %h expected 08 ffffff80", obs_byte_en, obs_ld);
        end
        n_checks++;
        if (obs_lv !== 1'b1 || obs_cycles !== 5 || obs_pulses !== 1) begin
            n_errors++; $display("FAIL lb_timing: lv %b cycle %0d pulses %0d expected 1 5 1", obs_lv, obs_cycles, obs_pulses);
        end
        drive_access(1'b0, 1'b1, 1'b0, 3'b100, 32'h203, 64'h0, 64'h80123456, 2);
        n_checks++;
        if (obs_ld !== 64'h80 || obs_lv !== 1'b1) begin
            n_errors++; $display("FAIL lbu: ld %h lv %b expected 80 1", obs_ld, obs_lv);
        end
    endtask

    task automatic test_half_and_fault();
        drive_access(1'b0, 1'b0, 1'b1, F3_H, 32'h102, 64'hABCD1234, 64'h0, 1);
        n_checks++;
        if (obs_wdata !== 64'h12341234 || obs_byte_en !== 8'h0C) begin
            n_errors++; $display("FAIL sh: wdata %h be %h expected 12341234 0c", obs_wdata, obs_byte_en);
        end
        drive_access(1'b0, 1'b1, 1'b0, F3_H, 32'h101, 64'h0, 64'h0, 0);
        n_checks++;
        if (obs_af !== 1'b1 || obs_saw_ce !== 1'b0 || obs_stall_cycles !== 1 || obs_cycles !== 2) begin
            n_errors++; $display("FAIL lh_fault: af %b ce %b stall %0d cycles %0d expected 1 0 1 2", obs_af, obs_saw_ce, obs_stall_cycles, obs_cycles);
        end
    endtask

    task automatic test_timeout();
        drive_access(1'b0, 1'b1, 1'b0, F3_W, 32'h200, 64'h0, 64'h55555555, 99);
        n_checks++;
        if (obs_ce_cycles !== TMO || obs_be !== 1'b1 || obs_ld !== 64'h0) begin
            n_errors++; $display("FAIL timeout: ce_cycles %0d bus_err %b ld %h expected %0d 1 0", obs_ce_cycles, obs_be, obs_ld, TMO);
        end
        n_checks++;
        if (obs_stall_cycles !== TMO + 1 || obs_cycles !== TMO + 2) begin
            n_errors++; $display("FAIL timeout_len: stall %0d cycles %0d expected %0d %0d", obs_stall_cycles, obs_cycles, TMO + 1, TMO + 2);
        end
    endtask

    task automatic test_read_wins();
        drive_access(1'b0, 1'b1, 1'b1, F3_W, 32'h300, 64'h99, 64'h11223344, 0);
        n_checks++;
        if (obs_we !== 1'b0 || obs_lv !== 1'b1 || obs_ld !== 64'h11223344) begin
            n_errors++; $display("FAIL read_wins: we %b lv %b ld %h expected 0 1 11223344", obs_we, obs_lv, obs_ld);
        end
    endtask

    task automatic test_reset_mid_busy();
        @(posedge clk); #1;
        sel = 1'b0; rd = 1'b1; wr = 1'b0; f3 = F3_W; addr = 32'h340; ack_r = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (ce32 !== 1'b1) begin
            n_errors++; $display("FAIL busy_pre: ce %b expected 1", ce32);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (ce32 !== 1'b0 || stall32 !== 1'b0) begin
            n_errors++; $display("FAIL async_abort: ce %b stall %b expected 0 0", ce32, stall32);
        end
        rd = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        drive_access(1'b0, 1'b1, 1'b0, F3_H, 32'h302, 64'h0, 64'h8001_0000, 0);
        n_checks++;
        if (obs_lv !== 1'b1 || obs_ld !== 64'hFFFF_8001 || obs_cycles !== 3) begin
            n_errors++; $display("FAIL after_reset: lv %b ld %h cycles %0d expected 1 ffff8001 3", obs_lv, obs_ld, obs_cycles);
        end
    endtask

    task automatic test_dw64();
        drive_access(1'b1, 1'b1, 1'b0, 3'b110, 32'h1004, 64'h0, 64'h8000_0001_DEAD_BEEF, 0);
        n_checks++;
        if (obs_ld !== 64'h0000_0000_8000_0001 || obs_lv !== 1'b1 || obs_byte_en !== 8'hF0) begin
            n_errors++; $display("FAIL lwu64: ld %h lv %b be %h expected 0000000080000001 1 f0", obs_ld, obs_lv, obs_byte_en);
        end
        drive_access(1'b1, 1'b1, 1'b0, F3_W, 32'h1004, 64'h0, 64'h8000_0001_DEAD_BEEF, 1);
        n_checks++;
        if (obs_ld !== 64'hFFFF_FFFF_8000_0001 || obs_addr !== 32'h1000) begin
            n_errors++; $display("FAIL lw64: ld %h addr %h expected ffffffff80000001 1000", obs_ld, obs_addr);
        end
        drive_access(1'b0, 1'b1, 1'b0, 3'b110, 32'h1004, 64'h0, 64'h8000_0001, 0);
        n_checks++;
        if (obs_af !== 1'b1 || obs_saw_ce !== 1'b0) begin
            n_errors++; $display("FAIL lwu32: af %b ce %b expected 1 0", obs_af, obs_saw_ce);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  t_f3[3]  = '{3'b100, F3_B, 3'b101};
        logic [31:0] t_a[3]   = '{32'h401, 32'h402, 32'h406};
        logic        t_rd[3]  = '{1'b1, 1'b0, 1'b1};
        logic [63:0] r = 64'hC3B2_A190;
        for (int i = 0; i < 3; i++) begin
            drive_access(1'b0, t_rd[i], ~t_rd[i], t_f3[i], t_a[i], 64'h5A, r, 0);
            n_checks++;
            if (obs_cycles !== 3 || obs_lv !== t_rd[i] || obs_byte_en !== m_be(4, t_f3[i], t_a[i])) begin
                n_errors++; $display("FAIL b2b_%0d: cycles %0d lv %b be %h expected 3 %b %h", i, obs_cycles, obs_lv, obs_byte_en, t_rd[i], m_be(4, t_f3[i], t_a[i]));
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] exp_q[$];
        bit          ld_known[2] = '{1'b0, 1'b0};
        logic [63:0] last_ld[2];
        logic        s, r_rd, r_wr;
        int          nb, kind, w, size;
        logic [2:0]  rf3, exp_p;
        logic [31:0] a;
        logic [63:0] sdv, rdv, exp_ld;
        bit          flt, tmo;
        for (int it = 0; it < 60; it++) begin
            s    = 1'($urandom_range(0, 1));
            nb   = s ? 8 : 4;
            rf3  = 3'($urandom_range(0, 7));
            kind = $urandom_range(0, 2);
            r_rd = (kind != 1);
            r_wr = (kind != 0);
            a    = $urandom;
            w    = $urandom_range(0, 5);
            sdv  = {$urandom, $urandom};
            rdv  = {$urandom, $urandom};
            size = 1 << rf3[1:0];
            if ($urandom_range(0, 3) != 0) a = a & ~32'(size - 1);
            flt = m_fault(nb, rf3, a);
            tmo = !flt && (w >= TMO);
            exp_p = flt ? 3'b010 : tmo ? 3'b001 : r_rd ? 3'b100 : 3'b000;
            exp_ld = tmo ? 64'h0 : (!flt && r_rd) ? m_load(nb, rf3, a, rdv) : last_ld[s];
            if (tmo || (!flt && r_rd) || ld_known[s]) exp_q.push_back(exp_ld);
            drive_access(s, r_rd, r_wr, rf3, a, sdv, rdv, w);
            n_checks++;
            if ({obs_lv, obs_af, obs_be} !== exp_p || obs_pulses !== int'(exp_p != 3'b000)) begin
                n_errors++; $display("FAIL rnd%0d_pulse: got %b (%0d) expected %b", it, {obs_lv, obs_af, obs_be}, obs_pulses, exp_p);
            end
            n_checks++;
            if (obs_cycles !== (flt ? 2 : tmo ? TMO + 2 : 3 + w) || obs_moved !== 1'b0) begin
                n_errors++; $display("FAIL rnd%0d_timing: cycles %0d moved %b expected %0d 0", it, obs_cycles, obs_moved, flt ? 2 : tmo ? TMO + 2 : 3 + w);
            end
            if (!flt) begin
                n_checks++;
                if (obs_addr !== (a & ~32'(nb - 1)) || obs_byte_en !== m_be(nb, rf3, a) || obs_we !== ~r_rd ||
                    (!r_rd && obs_wdata !== m_wdata(nb, rf3, sdv))) begin
                    n_errors++; $display("FAIL rnd%0d_bus: addr %h be %h we %b wd %h expected %h %h %b %h", it, obs_addr, obs_byte_en, obs_we, obs_wdata, a & ~32'(nb - 1), m_be(nb, rf3, a), ~r_rd, m_wdata(nb, rf3, sdv));
                end
            end else begin
                n_checks++;
                if (obs_saw_ce !== 1'b0) begin
                    n_errors++; $display("FAIL rnd%0d_fault_ce: ce seen %b expected 0", it, obs_saw_ce);
                end
            end
            if (exp_q.size() > 0) begin
                exp_ld = exp_q.pop_front();
                n_checks++;
                if (obs_ld !== exp_ld) begin
                    n_errors++; $display("FAIL rnd%0d_load_data: got %h expected %h", it, obs_ld, exp_ld);
                end
            end
            if (tmo || (!flt && r_rd)) begin
                last_ld[s]  = tmo ? 64'h0 : m_load(nb, rf3, a, rdv);
                ld_known[s] = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_byte();
        test_half_and_fault();
        test_timeout();
        test_read_wins();
        test_reset_mid_busy();
        test_dw64();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Pipelined load/store stage for the RISC-V core, replacing the purely combinational memory-enable logic. It accepts one load or store per instruction from the EX/MEM register, checks size and alignment, drives a byte-lane data-memory port with ce/we/ack handshaking and wait states, and returns sign- or zero-extended load data. It stalls the pipeline until the access completes, faults, or times out.

Parameters:
DATA_W, 32, data bus width in bits; must be 32 or 64; lanes NB = DATA_W/8
ADDR_W, 32, address width
TIMEOUT, 16, maximum BUSY cycles without ack before a bus error; must be ≥1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
read_mem  in  1  load request from the EX/MEM register
write_mem  in  1  store request from the EX/MEM register
funct3  in  3  RISC-V size/sign code: [1:0] log2 bytes, [2] unsigned
result  in  ADDR_W  effective address from the ALU
store_data  in  DATA_W  rs2 value for stores
ce  out  1  memory chip enable
we  out  1  memory write enable
data_addr  out  ADDR_W  word-aligned address (low log2(NB) bits forced to 0)
byte_en  out  NB  lane enables
wdata  out  DATA_W  lane-replicated store data
rdata  in  DATA_W  memory read data, valid when ack=1
ack  in  1  memory completion
stall  out  1  hold IF/ID/EX/MEM pipeline registers
load_data  out  DATA_W  extended load result
load_valid  out  1  one-cycle pulse when load_data is valid
addr_fault  out  1  one-cycle pulse for a misaligned or illegal-size access
bus_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - ce, we, stall, load_valid, addr_fault and bus_err are 0.
  - data_addr, byte_en, wdata and load_data are 0.
  - No output is ever driven to z.
- Request priority: req = read_mem | write_mem. If both are set, the read wins and we=0.
- Access size and legality:
  - size = 1 << funct3[1:0].
  - Illegal when size > NB, or when funct3[2]=1 and size = NB.
  - Unsigned word loads (LWU) are legal only when DATA_W=64.
  - Misaligned when result mod size != 0.
  - off = result[log2(NB)-1:0].
- States:
  - IDLE:
    - stall = req, combinational.
    - If req and the access is illegal or misaligned: addr_fault=1 next cycle, go to DONE, no memory access.
    - Else if req: register ce=1, we, data_addr, byte_en = ((1<<size)-1) << off, wdata = store_data[8*size-1:0] replicated across the bus; clear the wait counter; go to BUSY.
  - BUSY:
    - stall=1 and the bus outputs are held stable.
    - ack is sampled only in BUSY.
    - On ack: ce/we/byte_en drop to 0 next cycle. For a load, load_data = (rdata >> 8*off) truncated to size and sign-extended unless funct3[2]=1, with load_valid=1 next cycle. Go to DONE.
    - Without ack: increment the counter. When counter == TIMEOUT-1 and still no ack: drop ce, bus_err=1, load_data=0, go to DONE.
  - DONE:
    - stall=0. Exactly one of load_valid, addr_fault or bus_err is pulsed; a store that succeeds pulses none.
    - The pipeline advances at the end of this cycle.
    - Inputs are ignored (they still show the completed instruction).
    - Always return to IDLE.
- Latency:
  - Zero-wait load: 3 cycles (IDLE, BUSY with ack, DONE).
  - Each wait state adds 1 cycle.
  - Fault: 2 cycles.
- Back-to-back accesses: a new request seen in IDLE the cycle after DONE is accepted normally.
- load_data holds its value until the next load completes.
- Reset during BUSY aborts the access immediately, with ce=0 asynchronously.

Decomposition:
- Shared package (mem_pkg):
  - funct3 size/sign constants (F3_B=000, F3_H=001, F3_W=010, F3_D=011, unsigned bit 2).
  - State encoding IDLE/BUSY/DONE.
- One natural sub-module, mem_lane_align: combinational. It produces byte_en and wdata from funct3, off and store_data, and extracts/extends load data from rdata, funct3 and off. It is reused by the instruction-fetch path.

Test Plan:
1. DATA_W=32, SW to addr 0x104 with store_data 0xDEADBEEF, ack in the first BUSY cycle -> data_addr=0x104, byte_en=1111, we=1; stall for 2 cycles; no pulses.
2. LB from addr 0x203 with rdata=0x80xxxxxx, ack after 2 wait cycles -> byte_en=1000, load_data=0xFFFFFF80, load_valid pulses in the 5th cycle. The same case with LBU -> 0x00000080.
3. SH to addr 0x102 with store_data 0x1234 -> wdata=0x12341234, byte_en=1100. LH from 0x101 -> addr_fault pulse, ce never asserted, stall for 1 cycle.
4. LW with ack held low and TIMEOUT=4 -> ce high for exactly 4 cycles, then bus_err=1, load_data=0, pipeline released.
5. read_mem=write_mem=1 -> read performed, we=0. rst_n pulled low mid-BUSY -> ce=0 and stall=0 immediately; next request starts cleanly from IDLE.
6. DATA_W=64: LWU from 0x...4 with rdata upper word 0x8000_0001 -> load_data=0x0000_0000_8000_0001. The same LWU with DATA_W=32 -> addr_fault.
